// File: rtl/aes_de_ctrl.sv
// Round-robin front end for one combinational AES inverse-cipher core: captures a granted
// ciphertext/key pair, waits a fixed settle window, then holds the plaintext until taken.
`timescale 1ns/1ps

module aes_de #(
    parameter int LEN_KEY   = 128,
    parameter int NUM_ROUND = 10
) (
    input  logic [127:0]       data_in,
    input  logic [LEN_KEY-1:0] key,
    output logic [127:0]       data_out
);
    localparam int NK = LEN_KEY / 32;
    localparam int NW = 4 * (NUM_ROUND + 1);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c-row+4)%4)+row) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a [4];
        logic [7:0]   coef [4];
        logic [7:0]   b;
        r    = '0;
        coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[127-8*(4*c+j) -: 8];
            for (int row = 0; row < 4; row++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++) b = b ^ gf_mul(a[j], coef[(j-row+4)%4]);
                r[127-8*(4*c+row) -: 8] = b;
            end
        end
        return r;
    endfunction

    logic [31:0]  w [NW];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] st;

    always_comb begin
        rc  = 8'h01;
        tmp = '0;
        for (int i = 0; i < NK; i++) w[i] = key[LEN_KEY-1-32*i -: 32];
        for (int i = NK; i < NW; i++) begin
            tmp = w[i-1];
            if (i % NK == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
                rc  = xtime(rc);
            end else if (NK > 6 && i % NK == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-NK] ^ tmp;
        end
        st = data_in ^ {w[4*NUM_ROUND], w[4*NUM_ROUND+1], w[4*NUM_ROUND+2], w[4*NUM_ROUND+3]};
        for (int r = NUM_ROUND - 1; r >= 1; r--) begin
            st = inv_sub_bytes(inv_shift_rows(st)) ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            st = inv_mix_columns(st);
        end
        st       = inv_sub_bytes(inv_shift_rows(st)) ^ {w[0], w[1], w[2], w[3]};
        data_out = st;
    end
endmodule

// state | meaning
// IDLE  | arbitrating; req_ready strobes the granted requester
// WAIT  | core settling on data_q/key_q, cnt counting down
// DONE  | plaintext held on out_* until out_ready
module aes_de_ctrl #(
    parameter int  LEN_KEY   = 128,
    parameter int  NUM_ROUND = 10,
    parameter int  NUM_REQ   = 2,
    parameter int  LATENCY   = 2,
    localparam int IDW       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*128-1:0]     req_data,
    input  logic [NUM_REQ*LEN_KEY-1:0] req_key,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [127:0]               out_data,
    output logic [IDW-1:0]             out_id,
    output logic                       busy
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t             state;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     id_q;
    logic [3:0]         cnt;
    logic [127:0]       data_q;
    logic [LEN_KEY-1:0] key_q;
    logic [127:0]       core_out;
    logic               grant_found;
    logic [IDW-1:0]     grant_idx;

    function automatic logic [IDW-1:0] wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[IDW-1:0];
    endfunction

    aes_de #(
        .LEN_KEY   (LEN_KEY),
        .NUM_ROUND (NUM_ROUND)
    ) u_aes_de (
        .data_in  (data_q),
        .key      (key_q),
        .data_out (core_out)
    );

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_valid[wrap_idx(int'(rr_ptr), k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_idx(int'(rr_ptr), k);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == ST_IDLE && !rst && grant_found) req_ready[grant_idx] = 1'b1;
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            cnt       <= '0;
            id_q      <= '0;
            data_q    <= '0;
            key_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        data_q <= req_data[int'(grant_idx)*128 +: 128];
                        key_q  <= req_key[int'(grant_idx)*LEN_KEY +: LEN_KEY];
                        id_q   <= grant_idx;
                        cnt    <= 4'(LATENCY - 1);
                        rr_ptr <= wrap_idx(int'(grant_idx), 1);
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        out_data  <= core_out;
                        out_id    <= id_q;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_de_ctrl.sv
// Bench for aes_de_ctrl: ciphertexts come from a reference AES-128 encryptor applied to
// random plaintexts; grants follow a round-robin model, with latency/backpressure/reset checks.
`timescale 1ns/1ps

module tb_aes_de_ctrl;
    localparam int NREQ   = 2;
    localparam int LAT    = 2;
    localparam int NREQ_B = 3;
    localparam int LAT_B  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [NREQ-1:0]       req_valid, req_ready;
    logic [NREQ*128-1:0]   req_data, req_key;
    logic                  out_valid, out_ready, busy;
    logic [127:0]          out_data;
    logic [0:0]            out_id;

    logic                  b_rst;
    logic [NREQ_B-1:0]     b_req_valid, b_req_ready;
    logic [NREQ_B*128-1:0] b_req_data, b_req_key;
    logic                  b_out_valid, b_out_ready, b_busy;
    logic [127:0]          b_out_data;
    logic [1:0]            b_out_id;

    aes_de_ctrl #(.LEN_KEY(128), .NUM_ROUND(10), .NUM_REQ(NREQ), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_key(req_key), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id), .busy(busy));

    aes_de_ctrl #(.LEN_KEY(128), .NUM_ROUND(10), .NUM_REQ(NREQ_B), .LATENCY(LAT_B)) dut_b (
        .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_data(b_req_data), .req_key(b_req_key), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_id(b_out_id), .busy(b_busy));

    int n_checks = 0;
    int n_fail   = 0;
    int exp_rr   = 0;
    int exp_rr_b = 0;
    logic [7:0] sbox [256];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
            sbox[p] = x;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] aes128_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] rk [176];
        logic [7:0] tmp [4];
        logic [7:0] rc, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            rk[i] = key[127-8*i -: 8];
            s[i]  = pt[127-8*i -: 8] ^ rk[i];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = rk[i-4+j];
            if (i % 16 == 0) begin
                tmp = '{sbox[rk[i-3]] ^ rc, sbox[rk[i-2]], sbox[rk[i-1]], sbox[rk[i-4]]};
                rc  = xt(rc);
            end
            for (int j = 0; j < 4; j++) rk[i+j] = rk[i-16+j] ^ tmp[j];
        end
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[16*r+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int rr_pick(input logic [7:0] v, input int ptr, input int n);
        for (int k = 0; k < n; k++)
            if (v[(ptr + k) % n]) return (ptr + k) % n;
        return -1;
    endfunction

    task automatic do_txn(input logic [NREQ-1:0] vmask, input int bp, input bit corrupt,
                          input bit use_vec);
        logic [127:0] pt [NREQ];
        logic [127:0] k;
        int g, w;
        w = 0;
        while (busy && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("idle_before_req", 128'(busy), 128'd0);
        for (int i = 0; i < NREQ; i++) begin
            pt[i] = rand128();
            k     = rand128();
            req_data[i*128 +: 128] = aes128_enc(pt[i], k);
            req_key[i*128 +: 128]  = k;
        end
        if (use_vec) begin
            pt[0]           = 128'h00112233445566778899aabbccddeeff;
            req_data[127:0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
            req_key[127:0]  = 128'h000102030405060708090a0b0c0d0e0f;
        end
        req_valid = vmask;
        out_ready = 1'($urandom);
        #1;
        g = rr_pick(8'(vmask), exp_rr, NREQ);
        chk("grant", 128'(req_ready), 128'(1 << g));
        @(posedge clk);
        exp_rr = (g + 1) % NREQ;
        for (int c = 1; c <= LAT + 1; c++) begin
            @(negedge clk);
            chk("latency_out_valid", 128'(out_valid), 128'(c == LAT + 1));
            chk("ready_low_in_flight", 128'(req_ready), 128'd0);
            if (c == 1 && corrupt) begin
                req_data  = '0;
                for (int i = 0; i < NREQ; i++) req_key[i*128 +: 128] = rand128();
                req_valid = NREQ'($urandom);
            end
            out_ready = (c == LAT + 1) ? (bp == 0) : 1'($urandom);
        end
        for (int j = 0; j < bp; j++) begin
            @(negedge clk);
            chk("hold_out_valid", 128'(out_valid), 128'd1);
            chk("hold_out_data", out_data, pt[g]);
            chk("hold_out_id", 128'(out_id), 128'(g));
            chk("hold_ready_low", 128'(req_ready), 128'd0);
            out_ready = (j == bp - 1);
        end
        #1;
        chk("drain_no_accept", 128'(req_ready), 128'd0);
        chk("out_valid", 128'(out_valid), 128'd1);
        chk("out_data", out_data, pt[g]);
        chk("out_id", 128'(out_id), 128'(g));
        @(negedge clk);
        chk("drained_valid", 128'(out_valid), 128'd0);
        chk("drained_busy", 128'(busy), 128'd0);
        out_ready = 1'b0;
        req_valid = '0;
    endtask

    task automatic do_txn_b(input logic [NREQ_B-1:0] vmask);
        logic [127:0] pt [NREQ_B];
        logic [127:0] k;
        int g;
        for (int i = 0; i < NREQ_B; i++) begin
            pt[i] = rand128();
            k     = rand128();
            b_req_data[i*128 +: 128] = aes128_enc(pt[i], k);
            b_req_key[i*128 +: 128]  = k;
        end
        b_req_valid = vmask;
        #1;
        g = rr_pick(8'(vmask), exp_rr_b, NREQ_B);
        chk("b_grant", 128'(b_req_ready), 128'(1 << g));
        @(posedge clk);
        exp_rr_b = (g + 1) % NREQ_B;
        @(negedge clk);
        chk("b_latency_early", 128'(b_out_valid), 128'd0);
        b_req_valid = '0;
        @(negedge clk);
        chk("b_out_valid", 128'(b_out_valid), 128'd1);
        chk("b_out_data", b_out_data, pt[g]);
        chk("b_out_id", 128'(b_out_id), 128'(g));
        b_out_ready = 1'b1;
        @(negedge clk);
        chk("b_drained", 128'(b_out_valid), 128'd0);
        b_out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        build_sbox();
        rst = 1'b1; req_valid = '0; req_data = '0; req_key = '0; out_ready = 1'b0;
        b_rst = 1'b1; b_req_valid = '0; b_req_data = '0; b_req_key = '0; b_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        req_valid = '1;
        #1;
        chk("rst_req_ready", 128'(req_ready), 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_out_id", 128'(out_id), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        exp_rr = 0;

        // contention from reset: 0,1,0,1
        for (int t = 0; t < 4; t++) do_txn(2'b11, $urandom_range(0, 3), 1'b0, 1'b0);

        // known vector, input corruption after acceptance, 5 cycles of backpressure
        do_txn(2'b01, 5, 1'b1, 1'b1);

        // reset while the block is in flight
        req_data  = {rand128(), rand128()};
        req_key   = {rand128(), rand128()};
        req_valid = 2'b01;
        #1;
        chk("rstw_grant", 128'(req_ready), 128'd1);
        @(posedge clk);
        @(negedge clk);
        chk("rstw_busy_before", 128'(busy), 128'd1);
        rst       = 1'b1;
        req_valid = '0;
        @(negedge clk);
        chk("rstw_busy", 128'(busy), 128'd0);
        chk("rstw_out_valid", 128'(out_valid), 128'd0);
        rst    = 1'b0;
        exp_rr = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rstw_no_pulse", 128'(out_valid), 128'd0);
        end
        do_txn(2'b11, 0, 1'b0, 1'b0);

        for (int t = 0; t < 20; t++)
            do_txn(NREQ'($urandom_range(1, 3)), $urandom_range(0, 4), 1'($urandom), 1'b0);

        // second instance: three requesters, single settle cycle
        @(negedge clk);
        b_req_valid = '1;
        #1;
        chk("b_rst_req_ready", 128'(b_req_ready), 128'd0);
        @(negedge clk);
        b_rst       = 1'b0;
        b_req_valid = '0;
        exp_rr_b    = 0;
        do_txn_b(3'b100);
        for (int t = 0; t < 6; t++) do_txn_b(NREQ_B'($urandom_range(1, 7)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
